// File: rtl/wor_pkg.sv
// Shared definitions for the wired-OR bus blocks: state encoding, default
// bit timing and word width, and the even-parity helper.
package wor_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_W       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Returns 1 when the bits (data plus parity bit, zero-extended) have odd weight.
    function automatic logic even_parity_err(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/wor_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value.
module wor_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/wor_rx.sv
// Wired-OR bus frame receiver: start/data(MSB first)/even-parity/stop frames,
// delivered through a one-entry valid/ready buffer with error flags.
module wor_rx
    import wor_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_W       = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                perr_frame_q, perr_frame_d;
    logic                done;
    logic                s;
    logic                p_q;
    logic [1:0]          warm_q;

    wor_sync #(.RESET_VAL(1'b0)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (line_i),
        .q     (s)
    );

    // p holds its reset value until the synchronizer has flushed its reset
    // zeros, so a line held high across reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= 2'b00;
            p_q    <= 1'b1;
        end else begin
            warm_q <= {warm_q[0], 1'b1};
            p_q    <= warm_q[1] ? s : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_frame_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            perr_frame_q <= perr_frame_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        perr_frame_d = perr_frame_q;
        done         = 1'b0;

        if (state_q != IDLE && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (s && !p_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(CLKS_PER_BIT / 2 - 1);
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (s) begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = DATA_W'({shift_q, s});
                    cnt_d   = CNT_W'(CLKS_PER_BIT - 1);
                    if (idx_q == IDX_W'(DATA_W - 1))
                        state_d = PARITY;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    perr_frame_d = even_parity_err(64'({shift_q, s}));
                    cnt_d        = CNT_W'(CLKS_PER_BIT - 1);
                    state_d      = STOP;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One-entry output buffer; a completed frame that finds it full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (valid_o && ready_i)
                valid_o <= 1'b0;
            if (done) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shift_q;
                    parity_err_o <= perr_frame_q;
                    frame_err_o  <= s;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule
